// File: rtl/grid_pkg.sv
// Shared definitions for the square move sequencer: grid geometry, move
// direction encodings and the controller state type.
package grid_pkg;

    localparam int GRID_W  = 8;   // 160 px / 20
    localparam int GRID_H  = 6;   // 120 px / 20
    localparam int SQ_SIZE = 20;  // square edge in pixels

    localparam logic [1:0] DIR_UP    = 2'd0;  // y-1
    localparam logic [1:0] DIR_DOWN  = 2'd1;  // y+1
    localparam logic [1:0] DIR_LEFT  = 2'd2;  // x-1
    localparam logic [1:0] DIR_RIGHT = 2'd3;  // x+1

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ERASE,
        S_ERASE_TAIL,
        S_DRAW,
        S_DRAW_TAIL,
        S_ACK
    } state_t;

endpackage

// File: rtl/square_move_controller_stage_timer.sv
// stage_timer: cycle counter used to bound how long a pixel stage may run
// before it must report done.
//   clk, resetn : clock, async active-low reset
//   clear       : synchronous clear to 0 (has priority over enable)
//   enable      : count one per cycle, saturating at TIMEOUT
//   expired     : count has reached TIMEOUT
module stage_timer #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count;

    assign expired = (count == W'(TIMEOUT));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/square_move_controller.sv
// square_move_controller: sequences erase_square then draw_square for a
// one-cell move of the player square, after bounds-checking the target.
//   move_req/move_dir      : request, sampled only when idle
//   erase_done/draw_done   : done pulses from the two pixel stages
//   move_ack               : 1-cycle completion pulse, with move_blocked
//                            (target off-grid) and move_error (stage timeout)
//   busy                   : high whenever not idle
//   erase_resetn/draw_resetn : hold each stage in reset unless it is active
//   sel_draw, plot         : VGA mux select and write enable
//   COUNTER_X/Y            : grid cell fed to the active stage
//   pos_x/pos_y            : committed square position
module square_move_controller
    import grid_pkg::*;
#(
    parameter int GRID_W  = grid_pkg::GRID_W,
    parameter int GRID_H  = grid_pkg::GRID_H,
    parameter int START_X = 0,
    parameter int START_Y = 0,
    parameter int TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       move_req,
    input  logic [1:0] move_dir,
    input  logic       erase_done,
    input  logic       draw_done,
    output logic       move_ack,
    output logic       move_blocked,
    output logic       move_error,
    output logic       busy,
    output logic       erase_resetn,
    output logic       draw_resetn,
    output logic       sel_draw,
    output logic       plot,
    output logic [3:0] COUNTER_X,
    output logic [3:0] COUNTER_Y,
    output logic [3:0] pos_x,
    output logic [3:0] pos_y
);

    state_t state, state_nxt;

    logic [1:0]        dir_q;
    logic [3:0]        tgt_x, tgt_y;
    logic              blocked_q, error_q;
    logic signed [4:0] dx, dy, tx, ty;
    logic              oob;
    logic              tmr_run, tmr_expired;

    // Target cell in 5-bit signed math so a step off the left/top edge
    // shows up as a negative value rather than wrapping.
    always_comb begin
        dx = '0;
        dy = '0;
        case (dir_q)
            DIR_UP:    dy = -5'sd1;
            DIR_DOWN:  dy =  5'sd1;
            DIR_LEFT:  dx = -5'sd1;
            DIR_RIGHT: dx =  5'sd1;
        endcase
    end

    assign tx  = $signed({1'b0, pos_x}) + dx;
    assign ty  = $signed({1'b0, pos_y}) + dy;
    assign oob = tx[4] || (int'(tx) >= GRID_W) || ty[4] || (int'(ty) >= GRID_H);

    // One timer serves both stages; it is held clear outside ERASE/DRAW so
    // each stage starts from zero.
    assign tmr_run = (state == S_ERASE) || (state == S_DRAW);

    stage_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (!tmr_run),
        .enable  (tmr_run),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Stage controls are a pure decode of state, so an async reset drops
    // them immediately and only one stage can ever be out of reset.
    always_comb begin
        state_nxt    = state;
        busy         = 1'b1;
        erase_resetn = 1'b0;
        draw_resetn  = 1'b0;
        sel_draw     = 1'b0;
        plot         = 1'b0;
        move_ack     = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (move_req) state_nxt = S_CHECK;
            end
            S_CHECK: state_nxt = oob ? S_ACK : S_ERASE;
            S_ERASE: begin
                erase_resetn = 1'b1;
                plot         = 1'b1;
                if (erase_done)       state_nxt = S_ERASE_TAIL;
                else if (tmr_expired) state_nxt = S_ACK;
            end
            // Tail cycle keeps plot high for the pixel registered on the
            // done edge.
            S_ERASE_TAIL: begin
                erase_resetn = 1'b1;
                plot         = 1'b1;
                state_nxt    = S_DRAW;
            end
            S_DRAW: begin
                draw_resetn = 1'b1;
                sel_draw    = 1'b1;
                plot        = 1'b1;
                if (draw_done)        state_nxt = S_DRAW_TAIL;
                else if (tmr_expired) state_nxt = S_ACK;
            end
            S_DRAW_TAIL: begin
                draw_resetn = 1'b1;
                sel_draw    = 1'b1;
                plot        = 1'b1;
                state_nxt   = S_ACK;
            end
            S_ACK: begin
                move_ack  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign move_blocked = blocked_q;
    assign move_error   = error_q;

    // Position / counter datapath. COUNTER only moves on the CHECK->ERASE
    // and ERASE_TAIL->DRAW transitions, i.e. before the stage leaves reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dir_q     <= '0;
            tgt_x     <= 4'(START_X);
            tgt_y     <= 4'(START_Y);
            pos_x     <= 4'(START_X);
            pos_y     <= 4'(START_Y);
            COUNTER_X <= 4'(START_X);
            COUNTER_Y <= 4'(START_Y);
            blocked_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (move_req) dir_q <= move_dir;
                S_CHECK: begin
                    if (oob) begin
                        blocked_q <= 1'b1;
                    end else begin
                        tgt_x     <= tx[3:0];
                        tgt_y     <= ty[3:0];
                        COUNTER_X <= pos_x;
                        COUNTER_Y <= pos_y;
                    end
                end
                S_ERASE: if (!erase_done && tmr_expired) error_q <= 1'b1;
                S_ERASE_TAIL: begin
                    COUNTER_X <= tgt_x;
                    COUNTER_Y <= tgt_y;
                end
                // Old cell is already erased, so a draw timeout still
                // commits the new position.
                S_DRAW: begin
                    if (!draw_done && tmr_expired) begin
                        error_q <= 1'b1;
                        pos_x   <= tgt_x;
                        pos_y   <= tgt_y;
                    end
                end
                S_DRAW_TAIL: begin
                    pos_x <= tgt_x;
                    pos_y <= tgt_y;
                end
                S_ACK: begin
                    blocked_q <= 1'b0;
                    error_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_square_move_controller.sv
module tb_square_move_controller;

    localparam int TIMEOUT = 1023;
    localparam int GW = 8;
    localparam int GH = 6;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       move_req = 1'b0;
    logic [1:0] move_dir = 2'd0;
    logic       erase_done = 1'b0;
    logic       draw_done = 1'b0;
    logic       move_ack, move_blocked, move_error, busy;
    logic       erase_resetn, draw_resetn, sel_draw, plot;
    logic [3:0] COUNTER_X, COUNTER_Y, pos_x, pos_y;

    square_move_controller #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn), .move_req(move_req), .move_dir(move_dir),
        .erase_done(erase_done), .draw_done(draw_done),
        .move_ack(move_ack), .move_blocked(move_blocked), .move_error(move_error),
        .busy(busy), .erase_resetn(erase_resetn), .draw_resetn(draw_resetn),
        .sel_draw(sel_draw), .plot(plot),
        .COUNTER_X(COUNTER_X), .COUNTER_Y(COUNTER_Y), .pos_x(pos_x), .pos_y(pos_y)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int blocked, error, px, py;
        int e_seen, ex, ey, d_seen, dxp, dyp;
        int plots, lat, req_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_mis = 0;
    int   cyc = 0;
    int   te = 3, td = 3;
    bit   ekill = 0, dkill = 0, stray = 0;
    int   e_seen = 0, ex = 0, ey = 0, d_seen = 0, dxs = 0, dys = 0;
    int   plot_cnt = 0, viol = 0;
    int   mx = 0, my = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Pixel-stage stubs: count cycles out of reset, pulse done on cycle te/td,
    // and record which cell each stage was pointed at when it started.
    initial begin
        int ec, dc;
        ec = 0;
        dc = 0;
        forever begin
            @(negedge clk);
            if (erase_resetn) ec++; else ec = 0;
            if (draw_resetn)  dc++; else dc = 0;
            if (ec == 1) begin e_seen = 1; ex = int'(COUNTER_X); ey = int'(COUNTER_Y); end
            if (dc == 1) begin d_seen = 1; dxs = int'(COUNTER_X); dys = int'(COUNTER_Y); end
            erase_done = !ekill && (ec == te);
            draw_done  = (!dkill && (dc == td)) || (stray && (ec == 5));
        end
    end

    // Monitor: structural invariants every cycle, scoreboard pop on each ack.
    initial begin
        bit   prev_er, prev_dr;
        exp_t e;
        prev_er = 0;
        prev_dr = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                plot_cnt = 0; e_seen = 0; d_seen = 0;
                prev_er = 0; prev_dr = 0;
            end else begin
                if (plot) plot_cnt++;
                if (erase_resetn && draw_resetn) viol++;
                if (!erase_resetn && !draw_resetn && plot) viol++;
                if (plot && (sel_draw != draw_resetn)) viol++;
                if (draw_resetn && !prev_dr && !prev_er) viol++;
                if (!move_ack && (move_blocked || move_error)) viol++;
                if (move_ack) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_ack", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("blocked", int'(move_blocked), e.blocked);
                        chk("error", int'(move_error), e.error);
                        chk("pos_x", int'(pos_x), e.px);
                        chk("pos_y", int'(pos_y), e.py);
                        chk("latency", cyc - e.req_cyc, e.lat);
                        chk("plot_cycles", plot_cnt, e.plots);
                        chk("erase_ran", e_seen, e.e_seen);
                        chk("draw_ran", d_seen, e.d_seen);
                        if (e.e_seen != 0 && e_seen != 0) begin
                            chk("erase_x", ex, e.ex);
                            chk("erase_y", ey, e.ey);
                        end
                        if (e.d_seen != 0 && d_seen != 0) begin
                            chk("draw_x", dxs, e.dxp);
                            chk("draw_y", dys, e.dyp);
                        end
                        chk("ack_stage_resets", int'(erase_resetn) + int'(draw_resetn), 0);
                        chk("ack_busy", int'(busy), 1);
                    end
                    plot_cnt = 0; e_seen = 0; d_seen = 0;
                end
                prev_er = erase_resetn;
                prev_dr = draw_resetn;
            end
        end
    end

    // Reference model: one grid step, legal only if it stays on the grid.
    task automatic do_move(input int dir, input int t_e, input int t_d,
                           input bit ek, input bit dk, input bit dbl, input bit str);
        exp_t e;
        int   nx, ny, budget;
        nx = mx; ny = my;
        case (dir)
            0: ny = my - 1;
            1: ny = my + 1;
            2: nx = mx - 1;
            default: nx = mx + 1;
        endcase
        te = t_e; td = t_d; ekill = ek; dkill = dk; stray = str;
        e = '{blocked: 0, error: 0, px: mx, py: my, e_seen: 0, ex: mx, ey: my,
              d_seen: 0, dxp: nx, dyp: ny, plots: 0, lat: 2, req_cyc: 0};
        if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
            e.blocked = 1;
        end else if (ek) begin
            e.error = 1; e.e_seen = 1;
            e.plots = TIMEOUT + 1; e.lat = TIMEOUT + 3;
        end else if (dk) begin
            e.error = 1; e.e_seen = 1; e.d_seen = 1; e.px = nx; e.py = ny;
            e.plots = t_e + 1 + TIMEOUT + 1; e.lat = t_e + TIMEOUT + 4;
        end else begin
            e.e_seen = 1; e.d_seen = 1; e.px = nx; e.py = ny;
            e.plots = t_e + t_d + 2; e.lat = t_e + t_d + 4;
        end
        @(negedge clk);
        move_dir = 2'(dir);
        move_req = 1'b1;
        e.req_cyc = cyc;
        sb.push_back(e);
        @(negedge clk);
        move_req = 1'b0;
        budget = e.lat + 50;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            move_req = dbl && (k == 10);
            if (sb.size() == 0) break;
        end
        move_req = 1'b0;
        if (sb.size() != 0) begin
            chk("ack_seen", 0, 1);
            sb.delete();
        end
        mx = e.px; my = e.py;
        stray = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int waited;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pos_x", int'(pos_x), 0);
        chk("rst_pos_y", int'(pos_y), 0);
        chk("rst_counter", int'(COUNTER_X) + int'(COUNTER_Y), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_stage_resets", int'(erase_resetn) + int'(draw_resetn), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_flags", int'(move_ack) + int'(move_blocked) + int'(move_error), 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        do_move(3, 403, 403, 0, 0, 0, 0);  // (0,0) -> (1,0), nominal timing
        do_move(2, 5, 7, 0, 0, 0, 0);      // back to (0,0)
        do_move(0, 5, 5, 0, 0, 0, 0);      // up off the top: blocked
        do_move(2, 5, 5, 0, 0, 0, 0);      // left off the edge: blocked

        for (int i = 0; i < 20; i++)
            do_move(int'($urandom_range(0, 3)), int'($urandom_range(3, 40)),
                    int'($urandom_range(3, 40)), 0, 0, 0, 0);

        while (mx < GW - 1) do_move(3, int'($urandom_range(3, 12)), 4, 0, 0, 0, 0);
        while (my < GH - 1) do_move(1, 4, int'($urandom_range(3, 12)), 0, 0, 0, 0);
        do_move(3, 5, 5, 0, 0, 0, 0);      // (7,5) right: blocked
        do_move(1, 5, 5, 0, 0, 0, 0);      // (7,5) down: blocked

        do_move(2, 5, 5, 1, 0, 0, 0);      // erase never done: error, pos kept
        chk("erase_resetn_after_timeout", int'(erase_resetn), 0);
        do_move(0, 10, 5, 0, 1, 0, 0);     // draw never done: error, pos moves
        do_move(2, 30, 10, 0, 0, 1, 1);    // extra req + stray draw_done in ERASE

        // Async reset in the middle of DRAW
        te = 8; td = 60; ekill = 0; dkill = 0;
        @(negedge clk);
        move_dir = 2'd2;
        move_req = 1'b1;
        @(negedge clk);
        move_req = 1'b0;
        waited = 0;
        while (!draw_resetn && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("draw_reached", int'(draw_resetn), 1);
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_pos_x", int'(pos_x), 0);
        chk("midrst_pos_y", int'(pos_y), 0);
        chk("midrst_counter", int'(COUNTER_X) + int'(COUNTER_Y), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_stage_resets", int'(erase_resetn) + int'(draw_resetn), 0);
        chk("midrst_plot_sel", int'(plot) + int'(sel_draw), 0);
        chk("midrst_ack", int'(move_ack), 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        mx = 0; my = 0;
        repeat (2) @(negedge clk);
        do_move(3, 6, 6, 0, 0, 0, 0);      // restarts from (0,0)

        repeat (20) @(negedge clk);
        chk("invariants", viol, 0);
        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
